uart_debug_rx: RTL



---
 rtl/uart_debug_rx.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_debug_rx.sv
// Debug-UART receiver: 8N1 deserialiser plus an ASCII step/reset/inject command decoder.
// Define UART_DEBUG_RX_PARITY_EN to receive 8E1 frames with even-parity checking.
module uart_debug_rx #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115_200,
    parameter int N      = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         uart_rx,
    output logic [7:0]   rx_byte,
    output logic         rx_valid,
    output logic         frame_err,
    output logic         step_req,
    output logic         reset_req,
    output logic [N-1:0] inj_data,
    output logic         inj_valid,
    output logic         cmd_err
);
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT + 1);
    localparam int NW           = (N > 4) ? N : 4;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK
    } rx_state_t;

    typedef enum logic {CMD_IDLE, CMD_WAIT_HEX} cmd_state_t;

    logic [1:0]    rx_sync;
    logic          rx_s;
    logic          rx_prev;
    rx_state_t     rx_state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
`ifdef UART_DEBUG_RX_PARITY_EN
    logic          par_bad;
`endif
    cmd_state_t    cmd_state;
    logic [3:0]    nib;
    logic          nib_ok;
    logic [NW-1:0] nib_w;

    // Synchroniser resets to the idle level so reset never fabricates a start edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            rx_sync <= {rx_sync[0], uart_rx};
            rx_prev <= rx_sync[1];
        end
    end

    assign rx_s = rx_sync[1];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_state  <= RX_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_DEBUG_RX_PARITY_EN
            par_bad   <= 1'b0;
`endif
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        rx_state <= RX_START;
                        cnt      <= '0;
                    end
                end
                RX_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt      <= '0;
                        bit_idx  <= '0;
                        rx_state <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_DEBUG_RX_PARITY_EN
                            rx_state <= RX_PARITY;
`else
                            rx_state <= RX_STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`ifdef UART_DEBUG_RX_PARITY_EN
                RX_PARITY: begin
                    if (cnt == BIT_LAST) begin
                        cnt      <= '0;
                        par_bad  <= ^{shreg, rx_s};
                        rx_state <= RX_STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`endif
                RX_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            frame_err <= 1'b1;
                            rx_state  <= RX_BREAK;
`ifdef UART_DEBUG_RX_PARITY_EN
                        end else if (par_bad) begin
                            frame_err <= 1'b1;
                            rx_state  <= RX_IDLE;
`endif
                        end else begin
                            rx_byte  <= shreg;
                            rx_valid <= 1'b1;
                            rx_state <= RX_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RX_BREAK: begin
                    if (rx_s) rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Hex digit decode of the byte currently presented with rx_valid.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        nib    = 4'd0;
        nib_ok = 1'b0;
        if (rx_byte >= "0" && rx_byte <= "9") begin
            nib    = 4'(rx_byte - 8'd48);
            nib_ok = 1'b1;
        end else if (rx_byte >= "A" && rx_byte <= "F") begin
            nib    = 4'(rx_byte - 8'd55);
            nib_ok = 1'b1;
        end else if (rx_byte >= "a" && rx_byte <= "f") begin
            nib    = 4'(rx_byte - 8'd87);
            nib_ok = 1'b1;
        end
    end

    assign nib_w = NW'(nib);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cmd_state <= CMD_IDLE;
            step_req  <= 1'b0;
            reset_req <= 1'b0;
            inj_valid <= 1'b0;
            cmd_err   <= 1'b0;
            inj_data  <= '0;
        end else begin
            step_req  <= 1'b0;
            reset_req <= 1'b0;
            inj_valid <= 1'b0;
            cmd_err   <= 1'b0;
            if (rx_valid) begin
                if (cmd_state == CMD_WAIT_HEX) begin
                    cmd_state <= CMD_IDLE;
                    if (nib_ok) begin
                        inj_data  <= nib_w[N-1:0];
                        inj_valid <= 1'b1;
                    end else begin
                        cmd_err <= 1'b1;
                    end
                end else begin
                    case (rx_byte)
                        "S", "s":            step_req  <= 1'b1;
                        "R", "r":            reset_req <= 1'b1;
                        "D", "d":            cmd_state <= CMD_WAIT_HEX;
                        8'h0D, 8'h0A, 8'h20: begin end
                        default:             cmd_err   <= 1'b1;
                    endcase
                end
            end else if (frame_err && cmd_state == CMD_WAIT_HEX) begin
                // A corrupted operand byte aborts the pending data command.
                cmd_err   <= 1'b1;
                cmd_state <= CMD_IDLE;
            end
        end
    end

endmodule
